// File: rtl/fetch_ctrl_if.sv
// Fetch-control bus: hazard/branch/CP0 requests in, PC-register controls and counters out.
// The fetch controller owns the master side; the surrounding pipeline owns the slave side.
interface fetch_ctrl_if;
  logic [31:0] pc;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        pc_en;
  logic [31:0] npc;
  logic        f_adel;
  logic        f_nop;
  logic        flush_fd;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  // No valid/ready pairs here: every request is a level sampled in the cycle it is
  // presented, and every response is combinational in that same cycle.
  modport master (
    input  pc, stall, br_valid, br_target, exc_req, eret_req, epc,
    output pc_en, npc, f_adel, f_nop, flush_fd, fetch_cnt, stall_cnt
  );

  modport slave (
    output pc, stall, br_valid, br_target, exc_req, eret_req, epc,
    input  pc_en, npc, f_adel, f_nop, flush_fd, fetch_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: picks the next PC by fixed priority, traps illegal fetch
// addresses (AdEL) by freezing fetch until CP0 redirects, and counts fetches/stalls.
module fetch_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC
) (
  input  logic          clk,
  input  logic          reset,
  fetch_ctrl_if.master  bus,
  output logic          o_dbg_fault
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_bad;
  logic        w_redirect;
  logic        w_fetch_inc;
  logic        w_stall_inc;

  assign w_bad = (bus.pc[1:0] != 2'b00) || (bus.pc < IM_BASE) || (bus.pc > IM_LIMIT);
  assign w_redirect = bus.exc_req || bus.eret_req;
  assign w_fetch_inc = (r_state == RUN) && !bus.stall && !w_redirect;
  assign w_stall_inc = bus.stall && !w_redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Priority: reset, exception, eret, FAULT freeze, stall, AdEL, branch, sequential.
  always_comb begin
    w_next_state = r_state;
    bus.pc_en    = 1'b0;
    bus.npc      = bus.pc;
    bus.f_adel   = 1'b0;
    bus.f_nop    = 1'b0;
    bus.flush_fd = 1'b0;
    if (reset) begin
      w_next_state = RUN;
      bus.npc      = PC_RESET;
      bus.flush_fd = 1'b1;
    end else if (bus.exc_req) begin
      w_next_state = RUN;
      bus.npc      = EXC_ENTRY;
      bus.pc_en    = 1'b1;
      bus.flush_fd = 1'b1;
    end else if (bus.eret_req) begin
      w_next_state = RUN;
      bus.npc      = bus.epc;
      bus.pc_en    = 1'b1;
      bus.flush_fd = 1'b1;
    end else if (r_state == FAULT) begin
      bus.f_nop = 1'b1;
    end else if (bus.stall) begin
      // Keep the AdEL tag up until F/D is actually allowed to capture it.
      bus.f_adel = w_bad;
    end else if (w_bad) begin
      bus.f_adel   = 1'b1;
      w_next_state = FAULT;
    end else if (bus.br_valid) begin
      bus.npc   = bus.br_target;
      bus.pc_en = 1'b1;
    end else begin
      bus.npc   = bus.pc + 32'd4;
      bus.pc_en = 1'b1;
    end
  end

  assign bus.fetch_cnt = r_fetch_cnt;
  assign bus.stall_cnt = r_stall_cnt;
  assign o_dbg_fault   = (r_state == FAULT);

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer that drives the PC register's enable and next-PC inputs.
- Resolves stall, branch/jump redirect, exception entry and eret return by fixed priority.
- Detects illegal fetch addresses (AdEL) and freezes fetch until the exception is taken.
- Keeps fetch and stall counters for performance measurement.
- Sits between the hazard unit, D-stage branch logic, M-stage CP0 and the PC register.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset; also NPC output during reset
EXC_ENTRY, 32'h0000_4180, exception handler entry address
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
pc  in  32  current PC from the PC register
stall  in  1  hazard-unit stall request for F/D
br_valid  in  1  D-stage branch taken or jump present
br_target  in  32  redirect target, valid while br_valid=1
exc_req  in  1  M-stage exception taken this cycle (CP0)
eret_req  in  1  M-stage eret committing this cycle
epc  in  32  CP0 EPC value, valid while eret_req=1
pc_en  out  1  PC register write enable
npc  out  32  next PC to load into the PC register
f_adel  out  1  tag the F-stage instruction with AdEL (ExcCode 4)
f_nop  out  1  force the F/D register input to a bubble
flush_fd  out  1  clear the F/D register
fetch_cnt  out  32  instructions fetched into F/D
stall_cnt  out  32  cycles lost to stall

Behaviour:
- FSM states: RUN, FAULT. Reset state is RUN. fetch_cnt and stall_cnt reset to 0.
- While reset=1:
  - pc_en=0, npc=PC_RESET, f_adel=0, f_nop=0, flush_fd=1.
  - A reset asserted mid-FAULT returns the FSM to RUN on the next edge.
- bad = (pc[1:0]!=0) | (pc<IM_BASE) | (pc>IM_LIMIT). Comparisons are unsigned, 32-bit.
- npc/pc_en priority, evaluated combinationally from current inputs:
  1. exc_req: npc=EXC_ENTRY, pc_en=1, flush_fd=1. Overrides stall and FAULT.
  2. eret_req: npc=epc, pc_en=1, flush_fd=1. Overrides stall and FAULT.
  3. state FAULT: pc_en=0, npc=pc, f_nop=1.
  4. stall: pc_en=0, npc=pc. br_valid is ignored; D holds the branch and re-presents it.
  5. bad (in RUN): pc_en=0, npc=pc, f_adel=1. The PC is not advanced past an illegal address.
  6. br_valid: npc=br_target, pc_en=1 (delay-slot instruction already in F).
  7. Otherwise: npc=pc+4, pc_en=1. Wraps modulo 2^32.
- f_adel:
  - Asserted only in RUN, when bad=1 and neither exc_req nor eret_req is active.
  - Stays asserted across stall cycles until F/D captures it.
- flush_fd is asserted only under rules 1 and 2 (and during reset).
- Transitions:
  - RUN to FAULT when bad & !stall & !exc_req & !eret_req. The tagged instruction is captured by F/D that edge.
  - FAULT to RUN when exc_req | eret_req.
  - Otherwise the state holds.
- Simultaneous exc_req and eret_req: exc_req wins, npc=EXC_ENTRY.
- fetch_cnt:
  - +1 on every edge where state=RUN, !stall, !exc_req, !eret_req and !reset.
  - Includes the edge that captures an AdEL-tagged instruction.
  - Excludes FAULT bubbles.
- stall_cnt: +1 on every edge where stall & !exc_req & !eret_req & !reset.
- Both counters wrap from 32'hFFFF_FFFF to 0 with no flag.
- All outputs except counters and state are combinational, so zero-cycle latency from inputs. The new PC appears one edge later via the PC register.

Test Plan:
1. Reset then 3 free-run cycles with pc=0x3000, 0x3004, 0x3008: npc=pc+4, pc_en=1 each cycle. fetch_cnt=3, stall_cnt=0.
2. pc=0x3010, stall=1 and br_valid=1 (target 0x3400) for 2 cycles, then stall=0: pc_en=0 and npc=0x3010 while stalled; then npc=0x3400, pc_en=1. stall_cnt=2.
3. pc=0x3002 with stall=1 for 1 cycle, then 0: f_adel=1 both cycles, pc_en=0. State becomes FAULT after the second edge. Next cycle f_nop=1, f_adel=0, pc_en=0.
4. In FAULT, assert exc_req: npc=0x4180, pc_en=1, flush_fd=1. State returns to RUN. fetch_cnt does not increment.
5. eret_req=1, epc=0x3020 with stall=1 and br_valid=1: npc=0x3020, pc_en=1, flush_fd=1, and stall_cnt unchanged. Then exc_req and eret_req together: npc=0x4180.
6. pc=0x7000 (above IM_LIMIT) gives f_adel=1. Separately, preload fetch_cnt near wrap via long run (or force), increment at 0xFFFF_FFFF gives 0. Assert reset mid-FAULT: state RUN, counters 0, npc=0x3000.
